data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
- Data-memory target for the 4-stage core's dmem interface; responds to the core's load/store requests.
- Accepts address, store data and the enable strobes driven from the core's decode stage.
- Returns load data registered one cycle later, which is when the core's execute/memory stage samples dmem_dataOut.
- Adds range checking, a sticky error flag and optional access statistics.

Parameters:
- DATA_WIDTH, 64, width of one memory word and of the data buses.
- ADDRESS_WIDTH, 32, width of the address bus from the core.
- MEM_DEPTH, 256, number of words; must be a power of two.
- INDEX_WIDTH, 8, log2(MEM_DEPTH); bits of the address used as the word index.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_enable  input  1  request valid this cycle.
- store_enable  input  1  1 = store, 0 = load; only meaningful when mem_enable=1.
- address  input  ADDRESS_WIDTH  word address, not byte address.
- data_in  input  DATA_WIDTH  store data.
- data_out  output  DATA_WIDTH  registered load data.
- rd_valid  output  1  pulses high for one cycle when data_out holds fresh load data.
- addr_err  output  1  sticky out-of-range flag.
- load_count  output  32  loads serviced (see Optional Feature).
- store_count  output  32  stores serviced (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, rd_valid=0, addr_err=0, load_count=0, store_count=0.
  - Array contents are NOT cleared and are retained across reset.
- In range: address[ADDRESS_WIDTH-1:INDEX_WIDTH]==0. Index = address[INDEX_WIDTH-1:0].
- Store, in range (mem_enable=1, store_enable=1): array[index] <= data_in at the edge. data_out holds. rd_valid=0 next cycle.
- Load, in range (mem_enable=1, store_enable=0): data_out <= array[index] at the edge. rd_valid=1 for exactly the following cycle. Latency is 1 clock.
- Idle (mem_enable=0):
  - data_out holds its last value and rd_valid <= 0.
  - store_enable is ignored.
- Out-of-range request:
  - Store: suppressed, so no array write.
  - Load: data_out <= 0 and rd_valid pulses as for a normal load.
  - addr_err <= 1 and stays set until reset. Counters are not incremented.
- Store then load to the same index on consecutive cycles: the load returns the newly stored data. There is no bypass requirement because the write completes at the earlier edge.
- Only one access per cycle, so a same-cycle read/write conflict cannot occur.
- Back-to-back loads: a new data_out every cycle and rd_valid held high continuously.
- Reset asserted mid-access: the in-flight load result is discarded (data_out=0). A store sampled on the same edge as reset assertion may or may not land; verification must not check it.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - load_count increments on each in-range load.
  - store_count increments on each in-range store.
  - Both saturate and both are cleared by reset.
- Not defined:
  - Counter registers are not instantiated and load_count/store_count are tied to 0.
  - All other behaviour is identical.

Decomposition:
- Shared package dmem_pkg holds:
  - constants DMEM_DEPTH, DMEM_INDEX_WIDTH and COUNT_WIDTH=32;
  - an access-kind enum (ACC_IDLE, ACC_LOAD, ACC_STORE) decoded from mem_enable/store_enable;
  - the function in_range(address).
- Sub-module dmem_array: single-port synchronous storage with write enable and registered read, no reset. The top level holds range checking, the error flag, rd_valid, the counters and the zeroing of out-of-range load data.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, mem_enable=0 for 5 cycles -> data_out=0, rd_valid=0, addr_err=0 throughout.
- Store/load round trip: store 64'hDEAD_BEEF_0123_4567 at address 5, load address 5 on the next cycle -> data_out=64'hDEAD_BEEF_0123_4567 one cycle after the load with rd_valid=1 for one cycle. With DMEM_STATS_EN: store_count=1, load_count=1.
- Back-to-back loads: preload addresses 0..3 with 10,20,30,40, then issue loads 0,1,2,3 on consecutive cycles -> data_out sequence 10,20,30,40 on the following 4 cycles, rd_valid high for all 4.
- Out-of-range: store 64'h1 at address 256, then load 256 -> array unchanged (a load of address 0 still returns its prior value), out-of-range load returns 0, addr_err=1 and stays high, counters unchanged.
- Idle hold and saturation: after a load returning 64'h55, hold mem_enable=0 with store_enable=1 -> data_out stays 64'h55 and no write occurs. With DMEM_STATS_EN, force load_count to 32'hFFFF_FFFE and do 3 loads -> load_count=32'hFFFF_FFFF.
- Reset retention: store 64'hA5 at address 7, pulse rst low mid-stream, then load 7 -> data_out=64'hA5, and addr_err/counters were cleared by the reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, access-kind decode and range check for the data memory responder
package dmem_pkg;

  localparam int DMEM_DEPTH       = 256;
  localparam int DMEM_INDEX_WIDTH = 8;
  localparam int COUNT_WIDTH      = 32;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } access_kind_e;

  function automatic access_kind_e decode_access(input logic mem_enable, input logic store_enable);
    if (!mem_enable)
      return ACC_IDLE;
    else if (store_enable)
      return ACC_STORE;
    else
      return ACC_LOAD;
  endfunction

  // Address is passed zero-extended so one function serves any address width.
  function automatic logic in_range(input logic [63:0] address, input int index_width);
    return (address >> index_width) == 64'd0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word storage with registered read, no reset
module dmem_array #(
  parameter int DATA_WIDTH  = 64,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rdata only changes on a read, so it holds across stores and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[index] <= wdata;
      else
        rdata <= mem[index];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - dmem target: range check, sticky error, registered load data
// Optional access statistics enabled by defining DMEM_STATS_EN.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH     = DMEM_DEPTH,
  parameter int INDEX_WIDTH   = DMEM_INDEX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_enable,
  input  logic                     store_enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     addr_err,
  output logic [COUNT_WIDTH-1:0]   load_count,
  output logic [COUNT_WIDTH-1:0]   store_count
);

  access_kind_e           kind;
  logic                   addr_ok;
  logic                   arr_en;
  logic [INDEX_WIDTH-1:0] index;
  logic [DATA_WIDTH-1:0]  arr_rdata;
  logic                   zero_q;

  always_comb kind = decode_access(mem_enable, store_enable);

  assign addr_ok = in_range(64'(address), INDEX_WIDTH) && (MEM_DEPTH == (1 << INDEX_WIDTH));
  assign index   = address[INDEX_WIDTH-1:0];
  assign arr_en  = (kind != ACC_IDLE) && addr_ok;

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (kind == ACC_STORE),
    .index(index),
    .wdata(data_in),
    .rdata(arr_rdata)
  );

  // The array read register has no reset, so zero_q masks it after reset
  // and after an out-of-range load until the next good load refreshes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      rd_valid <= (kind == ACC_LOAD);
      if (kind != ACC_IDLE && !addr_ok)
        addr_err <= 1'b1;
      if (kind == ACC_LOAD)
        zero_q <= !addr_ok;
    end
  end

  assign data_out = zero_q ? '0 : arr_rdata;

`ifdef DMEM_STATS_EN
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] load_cnt_q;
  logic [COUNT_WIDTH-1:0] store_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (addr_ok) begin
      if (kind == ACC_LOAD && load_cnt_q != COUNT_MAX)
        load_cnt_q <= load_cnt_q + 1'b1;
      if (kind == ACC_STORE && store_cnt_q != COUNT_MAX)
        store_cnt_q <= store_cnt_q + 1'b1;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`else
  assign load_count  = '0;
  assign store_count = '0;
`endif

endmodule
